// File: rtl/pmu_event_sync_if.sv
// Event bundle between the PMU event sources and the fast-to-slow event synchroniser.
// Carries fast-domain event/clear inputs and status, and slow-domain out/out_clr.
// master drives events and clears; slave (the synchroniser) drives out, busy, coal_cnt.
interface pmu_event_sync_if #(
  parameter int CH    = 4,
  parameter int CNT_W = 4
);
  logic [CH-1:0]       in;
  logic                cnt_clr;
  logic [CH-1:0]       out_clr;
  logic [CH-1:0]       out;
  logic [CH-1:0]       busy;
  logic [CH*CNT_W-1:0] coal_cnt;

  modport master (
    output in,
    output cnt_clr,
    output out_clr,
    input  out,
    input  busy,
    input  coal_cnt
  );

  modport slave (
    input  in,
    input  cnt_clr,
    input  out_clr,
    output out,
    output busy,
    output coal_cnt
  );
endinterface

// File: rtl/pmu_event_sync.sv
// Per-channel fast->slow event crossing using a 4-phase req/ack handshake with event coalescing.
// Latency: out rises on the (SYNC_STAGES+2)th slow_clk edge after the channel's req flop rises.
// No backpressure: events arriving mid-handshake are held as one pending event, extras are counted.
module pmu_event_sync #(
  parameter int CH          = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 4,
  parameter int OUT_PULSE   = 1
) (
  input logic              fast_clk,
  input logic              pad_cpu_rst_b,
  input logic              slow_clk,
  pmu_event_sync_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // ---------------------------------------------------------------------------
  // Fast domain: handshake FSM, pending flag and coalesce counter per channel
  // ---------------------------------------------------------------------------
  state_e           state_q   [CH];
  state_e           state_nxt [CH];
  logic [CH-1:0]    pend_q;
  logic [CH-1:0]    pend_nxt;
  logic [CNT_W-1:0] cnt_q     [CH];
  logic [CNT_W-1:0] cnt_nxt   [CH];
  logic [CH-1:0]    req_q;

  // ack returning from the slow domain, and its fast-side synchroniser chain
  logic [CH-1:0]    ack_sync  [SYNC_STAGES];
  logic [CH-1:0]    ack_s;

  // Slow domain: req synchroniser, edge detect and output state
  logic [CH-1:0]    req_sync  [SYNC_STAGES];
  logic [CH-1:0]    req_s;
  logic [CH-1:0]    ack;
  logic [CH-1:0]    req_d;
  logic [CH-1:0]    rise_q;
  logic [CH-1:0]    out_q;

  assign ack_s = ack_sync[SYNC_STAGES-1];
  assign req_s = req_sync[SYNC_STAGES-1];
  // The acknowledge is the last req synchroniser flop itself, so the return
  // path also starts straight from a flop.
  assign ack   = req_s;

  // Next state, pending capture and saturating coalesce count for every channel.
  always_comb begin
    state_nxt = state_q;
    pend_nxt  = pend_q;
    cnt_nxt   = cnt_q;
    for (int i = 0; i < CH; i++) begin
      case (state_q[i])
        IDLE: begin
          if (bus.in[i] || pend_q[i]) begin
            state_nxt[i] = REQ;
            pend_nxt[i]  = 1'b0;
          end
        end
        REQ: begin
          if (ack_s[i]) begin
            state_nxt[i] = DRAIN;
          end
        end
        DRAIN: begin
          if (!ack_s[i]) begin
            state_nxt[i] = IDLE;
          end
        end
        default: begin
          state_nxt[i] = IDLE;
        end
      endcase

      // An event during a handshake (including the DRAIN->IDLE cycle) is
      // remembered as one pending delivery.
      if (bus.in[i] && (state_q[i] != IDLE)) begin
        pend_nxt[i] = 1'b1;
      end

      // An event that finds a pending delivery already queued is merged into
      // it and only counted. This also covers an event in the IDLE cycle that
      // launches the pending delivery, so no event ever disappears uncounted.
      if (bus.in[i] && pend_q[i] && (cnt_q[i] != CNT_MAX)) begin
        cnt_nxt[i] = cnt_q[i] + 1'b1;
      end

      if (bus.cnt_clr) begin
        cnt_nxt[i] = '0;
      end
    end
  end

  // Fast-domain state registers; req is its own flop so nothing combinational
  // sits in front of the crossing.
  always_ff @(posedge fast_clk or negedge pad_cpu_rst_b) begin
    if (!pad_cpu_rst_b) begin
      state_q <= '{default: IDLE};
      pend_q  <= '0;
      cnt_q   <= '{default: '0};
      req_q   <= '0;
    end else begin
      state_q <= state_nxt;
      pend_q  <= pend_nxt;
      cnt_q   <= cnt_nxt;
      for (int i = 0; i < CH; i++) begin
        req_q[i] <= (state_nxt[i] == REQ);
      end
    end
  end

  // Bring the slow-domain ack back into fast_clk.
  always_ff @(posedge fast_clk or negedge pad_cpu_rst_b) begin
    if (!pad_cpu_rst_b) begin
      ack_sync <= '{default: '0};
    end else begin
      ack_sync[0] <= ack;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        ack_sync[k] <= ack_sync[k-1];
      end
    end
  end

  // Fast-side status: busy while a handshake is open, counters packed per channel.
  always_comb begin
    bus.busy     = '0;
    bus.coal_cnt = '0;
    for (int i = 0; i < CH; i++) begin
      bus.busy[i]                     = (state_q[i] != IDLE);
      bus.coal_cnt[i*CNT_W +: CNT_W]  = cnt_q[i];
    end
  end

  // ---------------------------------------------------------------------------
  // Slow domain
  // ---------------------------------------------------------------------------

  // Synchronise req into slow_clk and register the rising-edge detect, so out
  // (pulse or sticky) lands exactly SYNC_STAGES+2 slow edges after req rises.
  always_ff @(posedge slow_clk or negedge pad_cpu_rst_b) begin
    if (!pad_cpu_rst_b) begin
      req_sync <= '{default: '0};
      req_d    <= '0;
      rise_q   <= '0;
    end else begin
      req_sync[0] <= req_q;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        req_sync[k] <= req_sync[k-1];
      end
      req_d  <= req_s;
      rise_q <= req_s & ~req_d;
    end
  end

  // Delivered-event output: one-cycle pulse, or sticky with set beating clear.
  always_ff @(posedge slow_clk or negedge pad_cpu_rst_b) begin
    if (!pad_cpu_rst_b) begin
      out_q <= '0;
    end else if (OUT_PULSE != 0) begin
      out_q <= rise_q;
    end else begin
      out_q <= rise_q | (out_q & ~bus.out_clr);
    end
  end

  assign bus.out = out_q;

endmodule

// File: tb/tb_pmu_event_sync.sv
module tb_pmu_event_sync;

  localparam int CH = 4;
  localparam int SS = 2;
  localparam int CW = 4;

  logic          fast_clk;
  logic          slow_clk;
  logic          rst_b;
  int            slow_half = 20;

  logic [CH-1:0] in_v      = '0;
  logic [CH-1:0] out_clr_v = '0;
  logic          cnt_clr_v = 1'b0;

  int total  = 0;
  int bad    = 0;
  int slow_n = 0;

  // event bookkeeping: injected events (stimulus side), deliveries (observed out pulses)
  int inj   [CH];
  int deliv [CH];

  // expected delivery edges per channel (ring buffer)
  int            tgt [CH][16];
  int            wr  [CH];
  int            rd  [CH];
  logic [CH-1:0] busy_prev = '0;

  pmu_event_sync_if #(.CH(CH), .CNT_W(CW)) ifp ();
  pmu_event_sync_if #(.CH(CH), .CNT_W(CW)) ifs ();

  assign ifp.in      = in_v;
  assign ifp.cnt_clr = cnt_clr_v;
  assign ifp.out_clr = '0;
  assign ifs.in      = in_v;
  assign ifs.cnt_clr = cnt_clr_v;
  assign ifs.out_clr = out_clr_v;

  pmu_event_sync #(.CH(CH), .SYNC_STAGES(SS), .CNT_W(CW), .OUT_PULSE(1)) dut_p (
    .fast_clk      (fast_clk),
    .pad_cpu_rst_b (rst_b),
    .slow_clk      (slow_clk),
    .bus           (ifp)
  );

  pmu_event_sync #(.CH(CH), .SYNC_STAGES(SS), .CNT_W(CW), .OUT_PULSE(0)) dut_s (
    .fast_clk      (fast_clk),
    .pad_cpu_rst_b (rst_b),
    .slow_clk      (slow_clk),
    .bus           (ifs)
  );

  // fast posedges at 5 mod 10; slow posedges at 3 or 8 mod 10, never coincident
  initial begin
    fast_clk = 1'b0;
    forever #5 fast_clk = ~fast_clk;
  end

  initial begin
    slow_clk = 1'b0;
    #3;
    forever #(slow_half) slow_clk = ~slow_clk;
  end

  always @(posedge slow_clk) slow_n <= slow_n + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model input: each new handshake (busy 0->1) owes exactly one out pulse,
  // due on the (SS+2)th slow edge after it started.
  always @(posedge fast_clk) begin
    #1;
    for (int i = 0; i < CH; i++) begin
      if (rst_b && ifp.busy[i] && !busy_prev[i]) begin
        tgt[i][wr[i] % 16] = slow_n + SS + 2;
        wr[i]++;
      end
    end
    busy_prev = rst_b ? ifp.busy : '0;
  end

  // Compare process: every slow cycle, out must be high exactly on owed edges.
  always @(posedge slow_clk or negedge rst_b) begin
    if (!rst_b) begin
      for (int i = 0; i < CH; i++) rd[i] = wr[i];
    end else begin
      #1;
      for (int i = 0; i < CH; i++) begin
        logic e;
        e = (rd[i] != wr[i]) && (tgt[i][rd[i] % 16] == slow_n);
        chk($sformatf("out_pulse_ch%0d", i), ifp.out[i], e);
        if (e) rd[i]++;
        if (ifp.out[i]) deliv[i]++;
      end
    end
  end

  task automatic fast_cycle(input logic [CH-1:0] v);
    in_v = v;
    for (int i = 0; i < CH; i++) if (v[i]) inj[i]++;
    @(posedge fast_clk);
    #1;
    in_v = '0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (((ifp.busy != '0) || (ifs.busy != '0)) && (n < 2000)) begin
      @(posedge fast_clk);
      #1;
      n++;
    end
    chk(name, ifp.busy, 0);
    repeat (SS + 4) @(posedge slow_clk);
    #1;
  endtask

  task automatic slow_wait(input int n);
    repeat (n) @(posedge slow_clk);
    #1;
  endtask

  initial begin
    int n0;
    int n;
    int c;
    int b0;
    int bi [CH];
    int bd [CH];
    int ratios [5];
    logic [CH-1:0] v;

    ratios = '{1, 2, 3, 5, 8};

    // reset state
    rst_b = 1'b1;
    #2;
    rst_b = 1'b0;
    #1;
    chk("rst_out", ifp.out, 0);
    chk("rst_busy", ifp.busy, 0);
    chk("rst_coal", ifp.coal_cnt, 0);
    chk("rst_out_sticky", ifs.out, 0);
    repeat (3) @(posedge fast_clk);
    #1;
    rst_b = 1'b1;
    repeat (5) @(posedge fast_clk);
    #1;

    // single event on ch0: pulse on 4th slow edge after req
    b0 = deliv[0];
    fast_cycle(4'b0001);
    n0 = slow_n;
    chk("t1_busy_rise", ifp.busy[0], 1);
    n = -1;
    for (int k = 0; k < 40; k++) begin
      @(posedge slow_clk);
      #1;
      if (ifp.out[0]) begin
        n = slow_n - n0;
        break;
      end
    end
    chk("t1_latency_edges", n, 4);
    wait_idle("t1_idle");
    chk("t1_busy0", ifp.busy[0], 0);
    chk("t1_coal0", ifp.coal_cnt[CW-1:0], 0);
    chk("t1_deliveries", deliv[0] - b0, 1);

    // three events on ch1 within one handshake: two deliveries, one coalesced
    b0 = deliv[1];
    fast_cycle(4'b0010);
    repeat (2) fast_cycle(4'b0000);
    fast_cycle(4'b0010);
    repeat (2) fast_cycle(4'b0000);
    fast_cycle(4'b0010);
    wait_idle("t2_idle");
    chk("t2_deliveries", deliv[1] - b0, 2);
    chk("t2_coal1", ifp.coal_cnt[CW +: CW], 1);

    // ch2 held 40 cycles: counter saturates; cnt_clr beats a same-cycle event
    repeat (40) fast_cycle(4'b0100);
    chk("t3_coal2_sat", ifp.coal_cnt[2*CW +: CW], 15);
    cnt_clr_v = 1'b1;
    fast_cycle(4'b0100);
    cnt_clr_v = 1'b0;
    chk("t3_coal2_clr", ifp.coal_cnt[2*CW +: CW], 0);
    chk("t3_coal_all_clr", ifp.coal_cnt, 0);
    wait_idle("t3_idle");

    // sticky instance: hold until cleared; set wins over same-cycle clear
    out_clr_v = '1;
    slow_wait(2);
    chk("t4_sticky_cleared", ifs.out, 0);
    out_clr_v = '0;
    fast_cycle(4'b1000);
    wait_idle("t4_idle_a");
    slow_wait(10);
    chk("t4_sticky_hold", ifs.out, 4'b1000);
    out_clr_v = 4'b1000;
    slow_wait(1);
    chk("t4_sticky_clr", ifs.out[3], 0);
    fast_cycle(4'b1000);
    n0 = slow_n;
    for (int k = 1; k <= 8; k++) begin
      @(posedge slow_clk);
      #1;
      chk($sformatf("t4_setwins_edge%0d", k), ifs.out[3], (slow_n == n0 + 4) ? 1 : 0);
    end
    out_clr_v = '0;
    wait_idle("t4_idle_b");

    // reset while ch0 is in REQ
    b0 = deliv[0];
    fast_cycle(4'b0001);
    @(posedge fast_clk);
    #1;
    chk("t5_busy_before_rst", ifp.busy[0], 1);
    rst_b = 1'b0;
    #1;
    chk("t5_rst_out", ifp.out, 0);
    chk("t5_rst_busy", ifp.busy, 0);
    chk("t5_rst_coal", ifp.coal_cnt, 0);
    chk("t5_rst_sticky", ifs.out, 0);
    repeat (5) @(posedge fast_clk);
    #1;
    rst_b = 1'b1;
    slow_wait(30);
    chk("t5_no_spurious", deliv[0] - b0, 0);
    chk("t5_busy_after", ifp.busy, 0);

    // random events at several clock ratios: deliveries + coalesced = injected
    foreach (ratios[r]) begin
      rst_b = 1'b0;
      slow_half = 5 * ratios[r];
      slow_wait(2);
      @(posedge fast_clk);
      #1;
      rst_b = 1'b1;
      for (int i = 0; i < CH; i++) begin
        bi[i] = inj[i];
        bd[i] = deliv[i];
      end
      repeat (300) begin
        for (int i = 0; i < CH; i++) v[i] = ($urandom_range(29) == 0);
        fast_cycle(v);
      end
      wait_idle($sformatf("t6_idle_r%0d", ratios[r]));
      for (int i = 0; i < CH; i++) begin
        c = int'(ifp.coal_cnt[i*CW +: CW]);
        if (c < 15)
          chk($sformatf("t6_ident_r%0d_ch%0d", ratios[r], i), (deliv[i] - bd[i]) + c, inj[i] - bi[i]);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pmu_event_sync.md
PMU_EVENT_SYNC -- requirements
Module: pmu_event_sync

Interface
REQ-001 Parameter: CH, default 4, number of independent event channels (1..32).
REQ-002 Parameter: SYNC_STAGES, default 2, synchroniser flop depth per crossing (2..4).
REQ-003 Parameter: CNT_W, default 4, width of each per-channel coalesce counter (1..8).
REQ-004 Parameter: OUT_PULSE, default 1; 1 = out is a one-slow-cycle pulse per delivered event, 0 = out is sticky until out_clr.
REQ-005 Reset is pad_cpu_rst_b, asynchronous, active-low. The clock is fast_clk.
REQ-006 Port: fast_clk, input, 1, source-domain clock.
REQ-007 Port: pad_cpu_rst_b, input, 1, async active-low reset for both domains.
REQ-008 Port: slow_clk, input, 1, destination-domain clock, asynchronous to fast_clk.
REQ-009 Port: in, input, CH, fast domain; each cycle high on bit i is one event on channel i.
REQ-010 Port: cnt_clr, input, 1, fast domain; clears all coalesce counters.
REQ-011 Port: out_clr, input, CH, slow domain; clears sticky out[i] (used only when OUT_PULSE=0).
REQ-012 Port: out, output, CH, slow domain; delivered event indication.
REQ-013 Port: busy, output, CH, fast domain; channel i handshake in progress (state != IDLE).
REQ-014 Port: coal_cnt, output, CH*CNT_W, fast domain; channel i count at bits [i*CNT_W +: CNT_W].

Function
REQ-015 Each channel SHALL run an independent 4-phase req/ack handshake; there is no cross-channel interaction.
REQ-016 Fast-side FSM per channel: IDLE, REQ (req=1, waiting for ack_s=1), DRAIN (req=0, waiting for ack_s=0).
REQ-017 IDLE->REQ when in[i]=1 or pend[i]=1; req[i] SHALL be 1 on the following fast_clk edge; pend[i] is cleared on that transition.
REQ-018 REQ->DRAIN when the synchronised ack ack_s[i]=1; DRAIN->IDLE when ack_s[i]=0.
REQ-019 in[i]=1 while state is REQ or DRAIN (including the DRAIN->IDLE cycle) SHALL set pend[i].
REQ-020 If pend[i] is already 1 when such an event arrives, coal_cnt[i] SHALL increment by 1 and saturate at 2^CNT_W-1.
REQ-021 cnt_clr=1 SHALL zero all counters next edge and takes priority over a same-cycle increment.
REQ-022 req[i] SHALL be driven directly from a flop, with no combinational logic before the crossing.
REQ-023 Slow side: req[i] passes through SYNC_STAGES flops to give req_s[i]; ack[i]=req_s[i] is a flop output that passes through SYNC_STAGES fast_clk flops to give ack_s[i].
REQ-024 Slow-side rise detect: rise[i] = req_s[i] & ~req_d[i], where req_d is a one-flop delay.
REQ-025 When OUT_PULSE=1, out[i]=rise[i] registered; exactly one slow cycle high per delivered event.
REQ-026 When OUT_PULSE=0, out[i] is set by rise[i] and cleared by out_clr[i]; set wins on simultaneous set and clear.
REQ-027 Latency: out[i] SHALL rise on the (SYNC_STAGES+2)th slow_clk edge after req[i] rises.
REQ-028 Events SHALL never be lost, only coalesced: every IDLE->REQ transition yields exactly one out delivery.

Reset
REQ-029 While pad_cpu_rst_b=0, every flop in both domains SHALL clear asynchronously: state=IDLE, req=0, ack=0, pend=0, coal_cnt=0, out=0, busy=0.
REQ-030 Deassertion SHALL be usable without a synchroniser inside the block; the integrator guarantees it is released synchronously to each clock.
REQ-031 Reset mid-handshake SHALL abort the handshake with no delivery pending afterwards.

Verification
REQ-032 Setup CH=4, SYNC_STAGES=2, fast=4x slow; single pulse in=4'b0001 -> one out[0] pulse on the 4th slow edge after req; busy[0] returns to 0; coal_cnt[0]=0.
REQ-033 Three pulses on ch1 during one handshake -> exactly 2 out[1] deliveries; coal_cnt[1]=1.
REQ-034 in[2] held high for 40 fast cycles with CNT_W=4 -> coal_cnt[2] saturates at 15; cnt_clr together with an event gives 0.
REQ-035 OUT_PULSE=0, event on ch3 -> out[3] stays 1 until out_clr[3]; out_clr[3] in the same cycle as a new rise leaves out[3]=1.
REQ-036 Reset asserted while ch0 is in REQ -> all outputs 0 immediately; after release, no spurious out[0].
REQ-037 Random events on all channels with random clock ratios (1:1 to 8:1) -> scoreboard: deliveries + coalesced events = injected events per channel.
